sobel_gradient_unit: RTL and testbench
======================================

// Module: sobel_gradient_unit
// PURPOSE
//  - Compute the Sobel gradient of one 3x3 pixel window for the edge-detection datapath.
//  - The controller pulses start_calculation. The read stage then streams 9 pixels in raster order.
//  - The block computes Gx, Gy, the magnitude |Gx|+|Gy| and an edge flag against a threshold.
//  - It then pulses calculation_done back to the controller. The write stage consumes edge_out/mag_out.
// PARAMETERS
//  DATA_W   8    pixel width, unsigned
//  MAG_W    11   magnitude width (max 4*(2^DATA_W-1)*2 = 2040 fits 11b)
// PORTS
//  clk                input   1        system clock, rising edge
//  n_rst              input   1        asynchronous, active-low reset
//  start_calculation  input   1        1-cycle request to begin a new window
//  pixel_valid        input   1        pixel_data valid this cycle
//  pixel_data         input   DATA_W   pixel, raster order p0..p8 (p0 top-left, p8 bottom-right)
//  threshold          input   MAG_W    edge threshold, sampled when entering MAG
//  busy               output  1        high in every state except IDLE
//  calculation_done   output  1        1-cycle pulse, results valid
//  gx_out             output  MAG_W    signed Gx, held until next window completes
//  gy_out             output  MAG_W    signed Gy, held
//  mag_out            output  MAG_W    unsigned |Gx|+|Gy|, held
//  edge_out           output  1        mag_out >= threshold, held
// BEHAVIOUR
//  - Reset (asynchronous, active-low): all of the following are 0:
//      - state = IDLE and the pixel counter;
//      - all 9 pixel registers;
//      - outputs busy, calculation_done, gx_out, gy_out, mag_out, edge_out.
//  - FSM: IDLE -> LOAD -> GRAD -> MAG -> DONE -> IDLE.
//    - IDLE: on start_calculation=1, go to LOAD with the counter cleared.
//    - LOAD: on each pixel_valid=1, store pixel_data into p[cnt] and increment cnt.
//      - Gaps (pixel_valid=0) are allowed; the block waits indefinitely.
//      - The edge accepting p8 (cnt==8) moves to GRAD.
//    - GRAD: one edge registers gx_out and gy_out; go to MAG.
//      - Gx = (p2 + 2*p5 + p8) - (p0 + 2*p3 + p6)
//      - Gy = (p6 + 2*p7 + p8) - (p0 + 2*p1 + p2)
//      - Both are signed MAG_W; range is +/-1020 for DATA_W=8.
//    - MAG: one edge registers mag_out and edge_out; go to DONE.
//      - mag_out = |Gx| + |Gy|.
//      - edge_out = (mag_out >= threshold); the comparison uses the post-saturation value.
//    - DONE: calculation_done=1 (Moore output) for exactly one cycle; go to IDLE.
//  - Latency: calculation_done is high in the 3rd cycle after the edge that accepts p8.
//  - Outputs hold their values until the next MAG state overwrites them.
//  - Boundary conditions:
//    - start_calculation while busy: ignored, no restart.
//    - pixel_valid outside LOAD: ignored.
//    - start_calculation and pixel_valid in the same IDLE cycle: the pixel is NOT captured; loading begins next cycle.
//    - Reset mid-operation: immediate return to IDLE; a partial window is discarded and done is never pulsed.
//    - Arithmetic: all sums are computed in MAG_W+1 bits before truncation, so no intermediate overflow.
// CONFIGURATION
//  - SOBEL_SATURATE_EN defined:
//    - mag_out is clamped to 2^DATA_W-1 (255) when |Gx|+|Gy| exceeds it.
//    - edge_out compares against the clamped value.
//  - SOBEL_SATURATE_EN undefined:
//    - mag_out is the full unclamped MAG_W result (0..2040).
// TESTING
//  1. Uniform window, all pixels 100, threshold 50
//     -> gx=0, gy=0, mag=0, edge=0; done 3 cycles after p8.
//  2. Vertical edge, columns 0/0/255, threshold 500
//     -> gx=1020, gy=0, mag=1020, edge=1.
//     -> With SOBEL_SATURATE_EN: mag=255, edge=0.
//  3. Horizontal edge, rows 255/255/0 (top bright), threshold 0
//     -> gx=0, gy=-1020, mag=1020 (255 saturated), edge=1.
//  4. Pixels with random 0-3 cycle gaps; start_calculation re-pulsed mid-LOAD
//     -> same result as the gapless run; exactly one done pulse.
//  5. n_rst asserted after 5 pixels, then a new full window
//     -> no done for the aborted window; the new window result is correct; outputs 0 after reset.
//  6. Window chosen so mag=200 exactly, threshold 200 then 201
//     -> edge=1 then edge=0.

Source files
------------

// File: rtl/sobel_gradient_unit.sv
// Sobel gradient of one streamed 3x3 window: Gx, Gy, |Gx|+|Gy| and an edge flag.
// Define SOBEL_SATURATE_EN to clamp the magnitude to 2^DATA_W-1 before the threshold compare.
module sobel_gradient_unit #(
    parameter int DATA_W = 8,
    parameter int MAG_W  = 11
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_calculation,
    input  logic              pixel_valid,
    input  logic [DATA_W-1:0] pixel_data,
    input  logic [MAG_W-1:0]  threshold,
    output logic              busy,
    output logic              calculation_done,
    output logic [MAG_W-1:0]  gx_out,
    output logic [MAG_W-1:0]  gy_out,
    output logic [MAG_W-1:0]  mag_out,
    output logic              edge_out
);

    // state | meaning
    // IDLE  | waiting for start_calculation
    // LOAD  | capturing p0..p8 on pixel_valid
    // GRAD  | registering Gx/Gy, sampling threshold
    // MAG   | registering magnitude and edge flag
    // DONE  | one-cycle calculation_done pulse
    typedef enum logic [2:0] {IDLE, LOAD, GRAD, MAG, DONE} state_t;

    localparam int SUM_W = MAG_W + 1;

    state_t            state;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] p [9];
    logic [MAG_W-1:0]  thr_q;

    logic [SUM_W-1:0]  gx_pos, gx_neg, gy_pos, gy_neg;
    logic [SUM_W-1:0]  gx_full, gy_full;
    logic [SUM_W-1:0]  gx_sx, gy_sx, gx_abs, gy_abs, mag_sum;
    logic [MAG_W-1:0]  mag_next;

    function automatic logic [SUM_W-1:0] ext(input logic [DATA_W-1:0] v);
        return {{(SUM_W-DATA_W){1'b0}}, v};
    endfunction

    // Unsigned wrap-around subtraction in SUM_W bits gives the two's complement result.
    always_comb begin
        gx_pos  = ext(p[2]) + (ext(p[5]) << 1) + ext(p[8]);
        gx_neg  = ext(p[0]) + (ext(p[3]) << 1) + ext(p[6]);
        gy_pos  = ext(p[6]) + (ext(p[7]) << 1) + ext(p[8]);
        gy_neg  = ext(p[0]) + (ext(p[1]) << 1) + ext(p[2]);
        gx_full = gx_pos - gx_neg;
        gy_full = gy_pos - gy_neg;
    end

    always_comb begin
        gx_sx   = {gx_out[MAG_W-1], gx_out};
        gy_sx   = {gy_out[MAG_W-1], gy_out};
        gx_abs  = gx_out[MAG_W-1] ? ((~gx_sx) + SUM_W'(1)) : gx_sx;
        gy_abs  = gy_out[MAG_W-1] ? ((~gy_sx) + SUM_W'(1)) : gy_sx;
        mag_sum = gx_abs + gy_abs;
`ifdef SOBEL_SATURATE_EN
        if (mag_sum > SUM_W'((1 << DATA_W) - 1))
            mag_next = MAG_W'((1 << DATA_W) - 1);
        else
            mag_next = mag_sum[MAG_W-1:0];
`else
        mag_next = mag_sum[MAG_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= IDLE;
            cnt              <= '0;
            for (int i = 0; i < 9; i++) p[i] <= '0;
            thr_q            <= '0;
            busy             <= 1'b0;
            calculation_done <= 1'b0;
            gx_out           <= '0;
            gy_out           <= '0;
            mag_out          <= '0;
            edge_out         <= 1'b0;
        end else begin
            calculation_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_calculation) begin
                        state <= LOAD;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (pixel_valid) begin
                        for (int i = 0; i < 9; i++)
                            if (cnt == 4'(i)) p[i] <= pixel_data;
                        if (cnt == 4'd8)
                            state <= GRAD;
                        else
                            cnt <= cnt + 4'd1;
                    end
                end
                GRAD: begin
                    gx_out <= gx_full[MAG_W-1:0];
                    gy_out <= gy_full[MAG_W-1:0];
                    thr_q  <= threshold;
                    state  <= MAG;
                end
                MAG: begin
                    mag_out          <= mag_next;
                    edge_out         <= (mag_next >= thr_q);
                    calculation_done <= 1'b1;
                    state            <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_gradient_unit.sv
// Scoreboard bench for sobel_gradient_unit: directed windows with hand-computed results.
module tb_sobel_gradient_unit;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start_calculation = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [7:0]  pixel_data = '0;
    logic [10:0] threshold = '0;
    logic        busy, calculation_done, edge_out;
    logic [10:0] gx_out, gy_out, mag_out;

    sobel_gradient_unit #(.DATA_W(8), .MAG_W(11)) dut (
        .clk(clk), .n_rst(n_rst),
        .start_calculation(start_calculation),
        .pixel_valid(pixel_valid), .pixel_data(pixel_data),
        .threshold(threshold), .busy(busy),
        .calculation_done(calculation_done),
        .gx_out(gx_out), .gy_out(gy_out), .mag_out(mag_out),
        .edge_out(edge_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gx;
        int gy;
        int mag;
        int edg;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_count = 0;

`ifdef SOBEL_SATURATE_EN
    localparam int MAG1020 = 255;
    localparam int EDGE_T2 = 0;
`else
    localparam int MAG1020 = 1020;
    localparam int EDGE_T2 = 1;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst && calculation_done) begin
            exp_t e;
            done_count++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("gx", $signed(gx_out), e.gx);
                chk("gy", $signed(gy_out), e.gy);
                chk("mag", int'(mag_out), e.mag);
                chk("edge", int'(edge_out), e.edg);
                chk("done_latency", cyc - e.cyc, 2);
            end
        end
    end

    // Streams one window; start may share its cycle with a junk pixel that must be dropped.
    task automatic run_window(input logic [7:0] px [9], input int thr, input int max_gap,
                              input bit repulse, input bit junk_with_start, input exp_t e);
        threshold         = 11'(thr);
        start_calculation = 1'b1;
        pixel_valid       = junk_with_start;
        pixel_data        = 8'hFF;
        @(posedge clk); #1;
        start_calculation = 1'b0;
        pixel_valid       = 1'b0;
        chk("busy_in_load", int'(busy), 1);
        for (int i = 0; i < 9; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            if (repulse && i == 4) begin
                start_calculation = 1'b1;
                @(posedge clk); #1;
                start_calculation = 1'b0;
            end
            pixel_valid = 1'b1;
            pixel_data  = px[i];
            @(posedge clk); #1;
            pixel_valid = 1'b0;
            if (i == 8) begin
                e.cyc = cyc;
                sb.push_back(e);
            end
        end
        for (int k = 0; k < 10 && sb.size() != 0; k++) begin @(posedge clk); #1; end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk); #1;
        chk("busy_after_done", int'(busy), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(calculation_done), 0);
        chk({tag, "_gx"}, int'(gx_out), 0);
        chk({tag, "_gy"}, int'(gy_out), 0);
        chk({tag, "_mag"}, int'(mag_out), 0);
        chk({tag, "_edge"}, int'(edge_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w_flat [9];
        logic [7:0] w_vert [9];
        logic [7:0] w_horz [9];
        logic [7:0] w_m200 [9];
        logic [7:0] w_small [9];
        w_flat  = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
        w_vert  = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        w_horz  = '{255, 255, 255, 255, 255, 255, 0, 0, 0};
        w_m200  = '{0, 0, 0, 0, 0, 100, 0, 0, 0};
        w_small = '{0, 0, 10, 0, 0, 0, 0, 0, 0};

        #12;
        chk_zero("reset");
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;

        // Pixels offered while idle must be ignored.
        pixel_valid = 1'b1; pixel_data = 8'd7;
        repeat (3) begin @(posedge clk); #1; end
        pixel_valid = 1'b0;
        chk("idle_pixels_ignored", int'(busy), 0);

        run_window(w_flat, 50, 0, 1'b0, 1'b1, '{0, 0, 0, 0, 0});
        run_window(w_vert, 500, 0, 1'b0, 1'b0, '{1020, 0, MAG1020, EDGE_T2, 0});
        run_window(w_vert, 500, 3, 1'b1, 1'b0, '{1020, 0, MAG1020, EDGE_T2, 0});
        run_window(w_horz, 0, 0, 1'b0, 1'b0, '{0, -1020, MAG1020, 1, 0});

        // Abort a partial window with reset.
        start_calculation = 1'b1;
        @(posedge clk); #1;
        start_calculation = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1'b1; pixel_data = 8'(40 + i * 30);
            @(posedge clk); #1;
        end
        n_rst = 1'b0;
        #2;
        chk_zero("midreset");
        pixel_valid = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("no_done_after_abort", done_count, 4);

        run_window(w_small, 20, 0, 1'b0, 1'b0, '{10, -10, 20, 1, 0});
        run_window(w_m200, 200, 0, 1'b0, 1'b0, '{200, 0, 200, 1, 0});
        run_window(w_m200, 201, 2, 1'b0, 1'b0, '{200, 0, 200, 0, 0});

        repeat (5) begin @(posedge clk); #1; end
        chk("done_pulses", done_count, 7);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
